// File: rtl/vga_timing_if.sv
// Pixel-side bus of the VGA timing generator: advance enable, colour lookup
// address/data and the registered video outputs.
interface vga_timing_if;
    logic        clken;
    logic [23:0] vga_data;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_tick;

    modport master (
        input  clken, vga_data,
        output h_addr, v_addr, hsync, vsync, blank_n,
               vga_r, vga_g, vga_b, frame_tick
    );

    modport slave (
        output clken, vga_data,
        input  h_addr, v_addr, hsync, vsync, blank_n,
               vga_r, vga_g, vga_b, frame_tick
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: h/v counters, combinational pixel address,
// one registered stage for sync, blanking, colour and frame tick.
module vga_timing #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic         clkin,
    input  logic         rst,
    vga_timing_if.master bus
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_BEG = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_END = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_VIS_BEG = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_END = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hs0_s, vs0_s, valid0_s;
    logic [9:0]  h_addr_s, v_addr_s;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_n_q, blank_n_d;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_tick_q, frame_tick_d;

    // Raster counters: h wraps every line, v advances on the h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (bus.clken) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Stage 0: sync windows, visibility and pixel address from the counters.
    always_comb begin
        hs0_s    = (h_cnt_q < H_SYNC_W);
        vs0_s    = (v_cnt_q < V_SYNC_W);
        valid0_s = (h_cnt_q >= H_VIS_BEG) && (h_cnt_q < H_VIS_END) &&
                   (v_cnt_q >= V_VIS_BEG) && (v_cnt_q < V_VIS_END);
        if (valid0_s) begin
            h_addr_s = h_cnt_q - H_VIS_BEG;
            v_addr_s = v_cnt_q - V_VIS_BEG;
        end else begin
            h_addr_s = 10'd0;
            v_addr_s = 10'd0;
        end
    end

    // Stage 1 next state; frame_tick drops on any disabled edge.
    always_comb begin
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        blank_n_d    = blank_n_q;
        rgb_d        = rgb_q;
        frame_tick_d = 1'b0;
        if (bus.clken) begin
            hsync_d      = ~hs0_s;
            vsync_d      = ~vs0_s;
            blank_n_d    = valid0_s;
            rgb_d        = valid0_s ? bus.vga_data : 24'h000000;
            frame_tick_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end else begin
            frame_tick_d = 1'b0;
        end
    end

    // State registers; reset overrides clken.
    always_ff @(posedge clkin) begin
        if (rst) begin
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            blank_n_q    <= 1'b0;
            rgb_q        <= 24'h000000;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            blank_n_q    <= blank_n_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.h_addr     = h_addr_s;
    assign bus.v_addr     = v_addr_s;
    assign bus.hsync      = hsync_q;
    assign bus.vsync      = vsync_q;
    assign bus.blank_n    = blank_n_q;
    assign bus.vga_r      = rgb_q[23:16];
    assign bus.vga_g      = rgb_q[15:8];
    assign bus.vga_b      = rgb_q[7:0];
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: lane 0 is a default 640x480 generator, lane 1 a tiny
// raster with random clken, random resets and random colour data.
module tb_vga_timing;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        blank_n;
        logic [23:0] rgb;
        logic        tick;
        logic [9:0]  ha;
        logic [9:0]  va;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int HSv[2] = '{96, 4};
    int HBv[2] = '{48, 3};
    int HAv[2] = '{640, 10};
    int HFv[2] = '{16, 2};
    int VSv[2] = '{2, 2};
    int VBv[2] = '{33, 2};
    int VAv[2] = '{480, 5};
    int VFv[2] = '{10, 1};
    int NCYC[2] = '{33000, 20000};

    logic [1:0] rst_r   = 2'b11;
    logic [1:0] clken_r = 2'b00;
    logic [7:0] salt_r [2];

    exp_t q0[$];
    exp_t q1[$];
    int   vectors    = 0;
    int   miscompares = 0;

    vga_timing_if bus0();
    vga_timing_if bus1();

    assign bus0.clken    = clken_r[0];
    assign bus1.clken    = clken_r[1];
    assign bus0.vga_data = {bus0.h_addr[7:0], bus0.v_addr[7:0], salt_r[0]};
    assign bus1.vga_data = {bus1.h_addr[7:0], bus1.v_addr[7:0], salt_r[1]};

    vga_timing u_dut0 (
        .clkin (clk),
        .rst   (rst_r[0]),
        .bus   (bus0)
    );

    vga_timing #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5),  .V_FRONT(1)
    ) u_dut1 (
        .clkin (clk),
        .rst   (rst_r[1]),
        .bus   (bus1)
    );

    // Raster position p (pixel clocks since frame start) -> visibility and address.
    function automatic void addr_of(input int l, input int p, output bit vis,
                                    output int ha, output int va);
        int ht, h, v;
        ht  = HSv[l] + HBv[l] + HAv[l] + HFv[l];
        h   = p % ht;
        v   = p / ht;
        vis = (h >= HSv[l] + HBv[l]) && (h < HSv[l] + HBv[l] + HAv[l]) &&
              (v >= VSv[l] + VBv[l]) && (v < VSv[l] + VBv[l] + VAv[l]);
        ha  = vis ? h - (HSv[l] + HBv[l]) : 0;
        va  = vis ? v - (VSv[l] + VBv[l]) : 0;
    endfunction

    task automatic chk(input string name, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d t=%0t got %h expected %h", name, l, $time, act, exp);
        end
    endtask

    // Stimulus and reference model: one expected output set per clock edge.
    initial begin
        int   pos [2];
        exp_t prev[2];
        exp_t e;
        bit   vis;
        int   ha, va, ht, ft;
        for (int l = 0; l < 2; l++) begin
            pos[l]  = 0;
            prev[l] = '0;
            salt_r[l] = 8'h00;
        end
        for (int cyc = 0; cyc < 33000; cyc++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (cyc < NCYC[l]) begin
                    ht = HSv[l] + HBv[l] + HAv[l] + HFv[l];
                    ft = ht * (VSv[l] + VBv[l] + VAv[l] + VFv[l]);
                    if (l == 0) begin
                        rst_r[l]   = (cyc < 3);
                        clken_r[l] = ($urandom_range(0, 19) != 0);
                        salt_r[l]  = 8'hA5;
                    end else begin
                        rst_r[l]   = (cyc < 3) || ($urandom_range(0, 399) == 0);
                        clken_r[l] = (cyc < 200) ? cyc[0] : 1'($urandom_range(0, 1));
                        salt_r[l]  = 8'($urandom);
                    end
                    if (rst_r[l]) begin
                        e = '0;
                        e.hsync = 1'b1;
                        e.vsync = 1'b1;
                        pos[l]  = 0;
                        prev[l] = e;
                    end else if (clken_r[l]) begin
                        addr_of(l, pos[l], vis, ha, va);
                        e.hsync   = !((pos[l] % ht) < HSv[l]);
                        e.vsync   = !((pos[l] / ht) < VSv[l]);
                        e.blank_n = vis;
                        e.rgb     = vis ? {ha[7:0], va[7:0], salt_r[l]} : 24'h000000;
                        e.tick    = (pos[l] == 0);
                        pos[l]    = (pos[l] + 1) % ft;
                        prev[l]   = e;
                    end else begin
                        e      = prev[l];
                        e.tick = 1'b0;
                    end
                    addr_of(l, pos[l], vis, ha, va);
                    e.ha = 10'(ha);
                    e.va = 10'(va);
                    if (l == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end else begin
                    rst_r[l]   = 1'b0;
                    clken_r[l] = 1'b0;
                end
            end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 0, 32'(q0.size()), 32'd0);
        chk("queue_drain", 1, 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: just after every edge, pop the expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                vectors++;
                chk("hsync",      0, 32'(bus0.hsync),      32'(e.hsync));
                chk("vsync",      0, 32'(bus0.vsync),      32'(e.vsync));
                chk("blank_n",    0, 32'(bus0.blank_n),    32'(e.blank_n));
                chk("rgb",        0, 32'({bus0.vga_r, bus0.vga_g, bus0.vga_b}), 32'(e.rgb));
                chk("frame_tick", 0, 32'(bus0.frame_tick), 32'(e.tick));
                chk("h_addr",     0, 32'(bus0.h_addr),     32'(e.ha));
                chk("v_addr",     0, 32'(bus0.v_addr),     32'(e.va));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                vectors++;
                chk("hsync",      1, 32'(bus1.hsync),      32'(e.hsync));
                chk("vsync",      1, 32'(bus1.vsync),      32'(e.vsync));
                chk("blank_n",    1, 32'(bus1.blank_n),    32'(e.blank_n));
                chk("rgb",        1, 32'({bus1.vga_r, bus1.vga_g, bus1.vga_b}), 32'(e.rgb));
                chk("frame_tick", 1, 32'(bus1.frame_tick), 32'(e.tick));
                chk("h_addr",     1, 32'(bus1.h_addr),     32'(e.ha));
                chk("v_addr",     1, 32'(bus1.v_addr),     32'(e.va));
            end
        end
    end

endmodule
